peak_load_gen: RTL
==================

// Module: peak_load_gen
// PURPOSE
// - Downstream consumer of the divided-pulse counter outputs (pulse2/4/8/16) in the peak-power example.
// - On a rising edge of the selected pulse, drives a WIDTH-bit load register that toggles for a
//   programmable burst. This produces deterministic switching-activity peaks for power-trace analysis.
// - Counts completed bursts so the bench can cross-check the peaks it sees in the trace.
// PARAMETERS
// - WIDTH        64     width of toggling load register load_q
// - LEN_W        4      width of burst_len
// - COOL_CYCLES  2      idle cycles enforced after each burst (>=1)
// - CNT_W        8      width of burst_count (saturating)
// - LFSR_SEED    'h1    nonzero load_q reset value, used only with PEAK_LOAD_LFSR_EN
// PORTS
// - clk          in   1      single clock, rising-edge
// - rst_n        in   1      asynchronous active-low reset
// - pulse_in     in   4      {pulse16,pulse8,pulse4,pulse2} from the counter
// - sel          in   2      index of trigger source within pulse_in
// - enable       in   1      arms trigger detection; low aborts a running burst
// - burst_len    in   LEN_W  burst length in cycles; 0 is treated as 1
// - load_q       out  WIDTH  toggling load register
// - busy         out  1      high while state != IDLE
// - burst_count  out  CNT_W  completed bursts, saturates at all-ones
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, busy=0, burst_count=0, prev=4'b0.
//   load_q resets to 0, or to LFSR_SEED when PEAK_LOAD_LFSR_EN is defined.
// - Edge detect: prev<=pulse_in every cycle (all 4 bits). trig = pulse_in[sel] & ~prev[sel].
//   Changing sel therefore causes no false edge.
// - FSM states: IDLE, BURST, COOL. All outputs are registered.
// - IDLE: on (trig & enable) at edge t: state<=BURST, rem<=max(burst_len,1)-1,
//   busy=1 after edge t. burst_len is latched here; later changes are ignored.
// - BURST: load_q updates at every edge while state==BURST, giving exactly max(burst_len,1)
//   updates, the first at edge t+1.
//   - rem==0 at an edge: state<=COOL, cnt<=COOL_CYCLES-1, burst_count+=1 (saturating).
//   - Otherwise rem<=rem-1.
//   - enable==0 at an edge: abort. No load_q update on that edge, state<=COOL,
//     burst_count is not incremented. Abort takes priority over completion.
// - COOL: triggers are ignored. After COOL_CYCLES edges, state<=IDLE and busy falls.
//   An edge arriving on the same cycle COOL exits is not captured.
// - load_q holds its value outside BURST.
// - Reset mid-burst: returns immediately to the reset values. No partial count is kept.
// - prev is sampled in every state, so a pulse held high through COOL does not retrigger.
//   Only a fresh rising edge in IDLE starts a burst.
// CONFIGURATION
// - PEAK_LOAD_LFSR_EN defined: load_q advances as a Fibonacci LFSR each BURST cycle
//   (taps chosen for WIDTH=64: bits 63,62,60,59; shift left, feedback into bit 0).
//   About 50% of bits toggle per cycle; never reaches all-zero from a nonzero seed.
// - PEAK_LOAD_LFSR_EN undefined: load_q <= ~load_q each BURST cycle (100% toggle, worst-case peak).
// TESTING
// - Reset: rst_n=0 with random inputs -> load_q=0 (LFSR: =LFSR_SEED), busy=0, burst_count=0.
//   Release shows no activity with enable=0.
// - sel=1, burst_len=3, enable=1, counter free-running -> every pulse4 rise gives 3 inversions of
//   load_q (0->all1->0->all1), busy high 3+2 cycles, burst_count +1 per burst.
// - burst_len=0, sel=0 -> single inversion per burst. A pulse2 edge arriving during COOL is ignored.
// - Abort: burst_len=10, drop enable on 4th BURST cycle -> load_q frozen after 3 updates,
//   COOL 2 cycles, burst_count unchanged.
// - Switch sel 0->3 while pulse_in[3]=1 and prev[3]=1 -> no trigger.
//   The next real pulse16 rise triggers.
// - Saturation: CNT_W=2, run 5 complete bursts -> burst_count sticks at 3.
//   Async reset mid-BURST -> immediate reset values.

Source files
------------

// File: rtl/peak_load_gen.sv
// peak_load_gen: rising edge of a selected divided pulse launches a burst that
// toggles a wide load register, producing repeatable switching-activity peaks.
// Build option: define PEAK_LOAD_LFSR_EN to advance load_q as a Fibonacci LFSR
// (about half the bits toggling per cycle) instead of full inversion each cycle.
module peak_load_gen #(
    parameter int unsigned     WIDTH       = 64,
    parameter int unsigned     LEN_W       = 4,
    parameter int unsigned     COOL_CYCLES = 2,
    parameter int unsigned     CNT_W       = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED  = 'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       pulse_in,
    input  logic [1:0]       sel,
    input  logic             enable,
    input  logic [LEN_W-1:0] burst_len,
    output logic [WIDTH-1:0] load_q,
    output logic             busy,
    output logic [CNT_W-1:0] burst_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] COOL  = 2'd2;

    localparam int unsigned COOL_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;
    localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(COOL_CYCLES - 1);

`ifdef PEAK_LOAD_LFSR_EN
    localparam logic LFSR_ON = 1'b1;
`else
    localparam logic LFSR_ON = 1'b0;
`endif

    // LFSR mode must never start from all-zero, so it resets to the seed.
    localparam logic [WIDTH-1:0] LOAD_RST = LFSR_ON ? LFSR_SEED : '0;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  rem_d;
    logic [COOL_W-1:0] cool_q;
    logic [COOL_W-1:0] cool_d;
    logic [3:0]        prev_q;
    logic [WIDTH-1:0]  load_d;
    logic              busy_d;
    logic [CNT_W-1:0]  count_d;
    logic              trig;

    // Next value of the load register for one burst cycle.
`ifdef PEAK_LOAD_LFSR_EN
    function automatic logic [WIDTH-1:0] next_load(input logic [WIDTH-1:0] cur);
        logic fb;
        fb = cur[WIDTH-1] ^ cur[WIDTH-2] ^ cur[WIDTH-4] ^ cur[WIDTH-5];
        return {cur[WIDTH-2:0], fb};
    endfunction
`else
    function automatic logic [WIDTH-1:0] next_load(input logic [WIDTH-1:0] cur);
        return ~cur;
    endfunction
`endif

    // Rising edge of the selected source; prev holds all bits so a sel change
    // compares against that bit's true history and cannot fake an edge.
    assign trig = pulse_in[sel] & ~prev_q[sel];

    // Pulse history, sampled in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 4'b0;
        end else begin
            prev_q <= pulse_in;
        end
    end

    // FSM state and burst bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cool_q  <= cool_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q      <= LOAD_RST;
            busy        <= 1'b0;
            burst_count <= '0;
        end else begin
            load_q      <= load_d;
            busy        <= busy_d;
            burst_count <= count_d;
        end
    end

    // Next-state and next-output logic; abort outranks burst completion.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cool_d  = cool_q;
        load_d  = load_q;
        count_d = burst_count;
        case (state_q)
            IDLE: begin
                if (trig && enable) begin
                    state_d = BURST;
                    rem_d   = (burst_len == LEN_W'(0)) ? LEN_W'(0) : burst_len - LEN_W'(1);
                end
            end
            BURST: begin
                if (!enable) begin
                    state_d = COOL;
                    cool_d  = COOL_INIT;
                end else begin
                    load_d = next_load(load_q);
                    if (rem_q == LEN_W'(0)) begin
                        state_d = COOL;
                        cool_d  = COOL_INIT;
                        if (burst_count != {CNT_W{1'b1}}) begin
                            count_d = burst_count + CNT_W'(1);
                        end
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            COOL: begin
                if (cool_q == COOL_W'(0)) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q - COOL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule
